// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline word width, NOP encoding, default reset PC and fetch FSM states
package pipe_pkg;
   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0;
   localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'h0;
   typedef enum logic {FS_RUN, FS_HALT} fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard/redirect controls, instruction-memory port and IF/ID outputs of the fetch stage
interface fetch_stage_if;
   logic Stall;
   logic Flush;
   logic BranchTaken;
   logic [pipe_pkg::WORD_W-1:0] BranchTarget;
   logic Jump;
   logic [pipe_pkg::WORD_W-1:0] JumpTarget;
   logic [pipe_pkg::WORD_W-1:0] ImemAddr;
   logic [pipe_pkg::WORD_W-1:0] ImemData;
   logic [pipe_pkg::WORD_W-1:0] IFID_Instr;
   logic [pipe_pkg::WORD_W-1:0] IFID_PCPlus4;
   logic IFID_Valid;
   logic Halted;
   logic [pipe_pkg::WORD_W-1:0] StallCount;
   modport master (
      input Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, ImemData,
      output ImemAddr, IFID_Instr, IFID_PCPlus4, IFID_Valid, Halted, StallCount
   );
   modport slave (
      output Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, ImemData,
      input ImemAddr, IFID_Instr, IFID_PCPlus4, IFID_Valid, Halted, StallCount
   );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: program-counter flop with synchronous reset to RESET_PC, load or hold
module pc_reg
   import pipe_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC
) (
   input logic clk,
   input logic rst,
   input logic load,
   input logic [WORD_W-1:0] d,
   output logic [WORD_W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst) q <= RESET_PC;
      else if (load) q <= d;
   end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction fetch and IF/ID register with a RUN/HALT fetch FSM.
// Define FETCH_STALL_COUNT_EN to enable the saturating stall-cycle counter on StallCount.
module fetch_stage
   import pipe_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
   parameter logic [WORD_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input logic Clk,
   input logic Rst,
   fetch_stage_if.master bus
);
   fetch_state_e state, state_nxt;
   logic [WORD_W-1:0] pc, pc_plus4, pc_nxt, target, ifid_instr, ifid_pcplus4;
   logic run, redirect, advance, bubble, pc_load, ifid_valid;
   always_comb begin
      run = state == FS_RUN;
      redirect = bus.Jump | bus.BranchTaken;
      target = bus.Jump ? bus.JumpTarget : bus.BranchTarget;
      pc_plus4 = pc + 32'd4;
      pc_nxt = redirect ? target & ~32'h3 : pc_plus4;
      pc_load = redirect | (run & ~bus.Stall);
      advance = run & ~redirect & ~bus.Stall & ~bus.Flush;
      bubble = redirect | (run & bus.Flush);
      state_nxt = redirect ? FS_RUN : (advance && bus.ImemData == HALT_WORD) ? FS_HALT : state;
   end
   always_ff @(posedge Clk) begin
      state <= Rst ? FS_RUN : state_nxt;
   end
   pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk(Clk),
      .rst(Rst),
      .load(pc_load),
      .d(pc_nxt),
      .q(pc)
   );
   // In HALT the halt word stays visible but is demoted to a bubble after its first cycle.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         ifid_instr <= NOP_INSTR;
         ifid_pcplus4 <= '0;
         ifid_valid <= 1'b0;
      end else if (advance) begin
         ifid_instr <= bus.ImemData;
         ifid_pcplus4 <= pc_plus4;
         ifid_valid <= 1'b1;
      end else if (bubble) begin
         ifid_instr <= NOP_INSTR;
         ifid_valid <= 1'b0;
      end else if (!run) begin
         ifid_valid <= 1'b0;
      end
   end
`ifdef FETCH_STALL_COUNT_EN
   logic [WORD_W-1:0] stall_count;
   always_ff @(posedge Clk) begin
      if (Rst) stall_count <= '0;
      else if (run && bus.Stall && !redirect && !(&stall_count)) stall_count <= stall_count + 32'd1;
   end
   assign bus.StallCount = stall_count;
`else
   assign bus.StallCount = '0;
`endif
   assign bus.ImemAddr = pc;
   assign bus.IFID_Instr = ifid_instr;
   assign bus.IFID_PCPlus4 = ifid_pcplus4;
   assign bus.IFID_Valid = ifid_valid;
   assign bus.Halted = state == FS_HALT;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a rule-level reference model
module tb_fetch_stage;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef FETCH_STALL_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   logic Clk = 1'b0;
   logic Rst = 1'b1;
   int total = 0;
   int passed = 0;
   int fails = 0;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] m_pc, m_instr, m_pcp4, m_cnt;
   logic m_valid, m_halted;
   fetch_stage_if bus();
   fetch_stage dut (.Clk(Clk), .Rst(Rst), .bus(bus));
   always #5 Clk = ~Clk;
   function automatic logic [31:0] imem(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : {a[15:0], ~a[15:0]};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic r, input logic st, input logic fl, input logic br,
                        input logic [31:0] bt, input logic jp, input logic [31:0] jt);
      Rst = r;
      bus.Stall = st;
      bus.Flush = fl;
      bus.BranchTaken = br;
      bus.BranchTarget = bt;
      bus.Jump = jp;
      bus.JumpTarget = jt;
   endtask
   // Reference: apply the fetch rules for one clock to the model, then compare every output.
   task automatic cycle(input string tag);
      logic [31:0] w;
      bus.ImemData = imem(bus.ImemAddr);
      w = imem(m_pc);
      if (Rst) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0; m_halted = 1'b0; m_cnt = 32'h0;
      end else if (bus.Jump || bus.BranchTaken) begin
         m_pc = (bus.Jump ? bus.JumpTarget : bus.BranchTarget) & 32'hFFFF_FFFC;
         m_instr = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
      end else if (m_halted) begin
         m_valid = 1'b0;
      end else if (bus.Stall) begin
         if (bus.Flush) begin m_instr = 32'h0; m_valid = 1'b0; end
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else if (bus.Flush) begin
         m_pc = m_pc + 4; m_instr = 32'h0; m_valid = 1'b0;
      end else begin
         m_instr = w; m_pcp4 = m_pc + 4; m_valid = 1'b1; m_halted = (w == HALT); m_pc = m_pc + 4;
      end
      @(posedge Clk);
      #1;
      chk({tag, ":pc"}, bus.ImemAddr, m_pc);
      chk({tag, ":instr"}, bus.IFID_Instr, m_instr);
      chk({tag, ":pcplus4"}, bus.IFID_PCPlus4, m_pcp4);
      chk({tag, ":valid"}, {31'h0, bus.IFID_Valid}, {31'h0, m_valid});
      chk({tag, ":halted"}, {31'h0, bus.Halted}, {31'h0, m_halted});
      chk({tag, ":stallcnt"}, bus.StallCount, CNT_EN ? m_cnt : 32'h0);
   endtask
   initial begin
      mem[32'h0] = 32'h2008_0001;
      mem[32'h4] = 32'h2009_0002;
      mem[32'h40] = HALT;
      mem[32'h80] = HALT;
      drive(1, 0, 0, 0, 0, 0, 0);
      bus.ImemData = 32'h0;
      cycle("rst0");
      cycle("rst1");
      chk("rst_pc", bus.ImemAddr, 32'h0);
      chk("rst_valid", {31'h0, bus.IFID_Valid}, 32'h0);
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle("seq0");
      chk("seq0_instr", bus.IFID_Instr, 32'h2008_0001);
      chk("seq0_pcp4", bus.IFID_PCPlus4, 32'h4);
      cycle("seq1");
      chk("seq1_instr", bus.IFID_Instr, 32'h2009_0002);
      chk("seq1_pcp4", bus.IFID_PCPlus4, 32'h8);
      drive(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle("stall");
      chk("stall_pc", bus.ImemAddr, 32'h8);
      chk("stall_cnt", bus.StallCount, CNT_EN ? 32'd3 : 32'd0);
      drive(0, 1, 0, 1, 32'h43, 0, 0);
      cycle("br_stall");
      chk("br_pc", bus.ImemAddr, 32'h40);
      chk("br_cnt", bus.StallCount, CNT_EN ? 32'd3 : 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle("halt_fetch");
      chk("halted", {31'h0, bus.Halted}, 32'h1);
      cycle("halt_hold0");
      cycle("halt_hold1");
      chk("halt_pc", bus.ImemAddr, 32'h44);
      drive(0, 0, 1, 0, 0, 0, 0);
      cycle("halt_flush");
      drive(0, 0, 0, 0, 0, 1, 32'h100);
      cycle("halt_jump");
      chk("jump_pc", bus.ImemAddr, 32'h100);
      drive(0, 0, 1, 0, 0, 0, 0);
      cycle("flush");
      drive(0, 1, 1, 0, 0, 0, 0);
      cycle("stall_flush");
      drive(0, 0, 0, 1, 32'h200, 1, 32'hFFFF_FFFF);
      cycle("jump_over_br");
      chk("wrap_setup_pc", bus.ImemAddr, 32'hFFFF_FFFC);
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle("wrap");
      chk("wrap_pc", bus.ImemAddr, 32'h0);
      chk("wrap_pcp4", bus.IFID_PCPlus4, 32'h0);
      drive(0, 1, 0, 0, 0, 0, 0);
      cycle("pre_rst_stall");
      drive(1, 1, 0, 0, 0, 0, 0);
      cycle("rst_in_stall");
      chk("rst_stall_cnt", bus.StallCount, 32'h0);
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 255), $urandom_range(0, 15) == 0,
               $urandom_range(0, 255));
         cycle("rnd");
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
